// File: rtl/lim_counter_chain.sv
// lim_counter_chain
//   Mixed-radix counter chain (stopwatch style). NUM_DIGITS cascaded digits,
//   digit i counts modulo L_i (byte i of LIMITS). Run/stop FSM, up/down
//   counting, saturating synchronous load, optional halt at end of range.
//
//   Optional build feature: define LIM_COUNTER_LAP_CAPTURE_EN to add the
//   lap_i input and a lap snapshot register; otherwise lap outputs are 0.
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   tick_i       count-enable strobe
//   start_i      STOPPED -> RUNNING
//   stop_i       RUNNING -> STOPPED
//   clear_i      zero digits, go STOPPED
//   dir_i        0 = up, 1 = down
//   load_i       load saturated load_val_i, go STOPPED
//   load_val_i   packed digit values for load
//   lap_i        lap capture strobe (only with LIM_COUNTER_LAP_CAPTURE_EN)
//   count_o      packed digit values
//   carry_o      one-cycle pulse on full-chain wrap/borrow
//   running_o    high in RUNNING
//   done_o       high in DONE
//   lap_count_o  lap snapshot
//   lap_valid_o  lap snapshot valid
//
// state    | meaning
// ---------+-------------------------------------------------
// STOPPED  | idle, ticks ignored, waits for start
// RUNNING  | counting on each tick
// DONE     | end of range reached with STOP_AT_END=1; only clear/load leave

module lim_counter_chain #(
    parameter int                        NUM_DIGITS  = 4,
    parameter int                        DIGIT_W     = 4,
    parameter logic [8*NUM_DIGITS-1:0]   LIMITS      = 32'h060A060A,
    parameter bit                        STOP_AT_END = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          tick_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic                          clear_i,
    input  logic                          dir_i,
    input  logic                          load_i,
`ifdef LIM_COUNTER_LAP_CAPTURE_EN
    input  logic                          lap_i,
`endif
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val_i,
    output logic [NUM_DIGITS*DIGIT_W-1:0] count_o,
    output logic                          carry_o,
    output logic                          running_o,
    output logic                          done_o,
    output logic [NUM_DIGITS*DIGIT_W-1:0] lap_count_o,
    output logic                          lap_valid_o
);

    localparam int NW = NUM_DIGITS * DIGIT_W;
    // one extra bit so a limit of 2^DIGIT_W is representable
    localparam int LW = DIGIT_W + 1;

    typedef enum logic [1:0] {
        S_STOPPED = 2'd0,
        S_RUNNING = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t          state_q;
    logic [NW-1:0]   count_q;
    logic            carry_q;

    logic [NW-1:0]   up_cnt_d;
    logic [NW-1:0]   dn_cnt_d;
    logic [NW-1:0]   load_sat_d;
    logic            up_end_d;
    logic            dn_end_d;
    logic [NW-1:0]   count_d;
    logic            end_hit_d;

    // Both directions are computed every cycle; dir_i only selects, so a
    // direction change between ticks cannot disturb the held value.
    always_comb begin
        logic [LW-1:0]      lim;
        logic [DIGIT_W-1:0] dmax;
        logic [DIGIT_W-1:0] d;
        logic [DIGIT_W-1:0] lv;
        logic               up_c;
        logic               dn_b;
        up_cnt_d   = '0;
        dn_cnt_d   = '0;
        load_sat_d = '0;
        lim        = '0;
        dmax       = '0;
        d          = '0;
        lv         = '0;
        up_c       = 1'b1;
        dn_b       = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lim  = LW'(LIMITS[8*i +: 8]);
            dmax = DIGIT_W'(lim - LW'(1));
            d    = count_q[i*DIGIT_W +: DIGIT_W];
            lv   = load_val_i[i*DIGIT_W +: DIGIT_W];

            // up: carry enters digit i only if every lower digit wrapped
            if (!up_c) begin
                up_cnt_d[i*DIGIT_W +: DIGIT_W] = d;
            end else if ({1'b0, d} >= lim - LW'(1)) begin
                up_cnt_d[i*DIGIT_W +: DIGIT_W] = '0;
            end else begin
                up_cnt_d[i*DIGIT_W +: DIGIT_W] = d + DIGIT_W'(1);
                up_c = 1'b0;
            end

            // down: an out-of-range digit snaps to max without borrowing
            if (!dn_b) begin
                dn_cnt_d[i*DIGIT_W +: DIGIT_W] = d;
            end else if (d == '0) begin
                dn_cnt_d[i*DIGIT_W +: DIGIT_W] = dmax;
            end else if ({1'b0, d} >= lim) begin
                dn_cnt_d[i*DIGIT_W +: DIGIT_W] = dmax;
                dn_b = 1'b0;
            end else begin
                dn_cnt_d[i*DIGIT_W +: DIGIT_W] = d - DIGIT_W'(1);
                dn_b = 1'b0;
            end

            load_sat_d[i*DIGIT_W +: DIGIT_W] = ({1'b0, lv} >= lim) ? dmax : lv;
        end
        up_end_d = up_c;
        dn_end_d = dn_b;
    end

    assign count_d   = dir_i ? dn_cnt_d : up_cnt_d;
    assign end_hit_d = dir_i ? dn_end_d : up_end_d;

`ifdef LIM_COUNTER_LAP_CAPTURE_EN
    logic [NW-1:0] lap_q;
    logic          lap_valid_q;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_STOPPED;
            count_q <= '0;
            carry_q <= 1'b0;
`ifdef LIM_COUNTER_LAP_CAPTURE_EN
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
`endif
        end else begin
            carry_q <= 1'b0;
`ifdef LIM_COUNTER_LAP_CAPTURE_EN
            // snapshot uses the pre-tick value; clear/load below override
            if (lap_i && state_q != S_STOPPED) begin
                lap_q       <= count_q;
                lap_valid_q <= 1'b1;
            end
`endif
            if (clear_i) begin
                count_q <= '0;
                state_q <= S_STOPPED;
`ifdef LIM_COUNTER_LAP_CAPTURE_EN
                lap_q       <= '0;
                lap_valid_q <= 1'b0;
`endif
            end else if (load_i) begin
                count_q <= load_sat_d;
                state_q <= S_STOPPED;
`ifdef LIM_COUNTER_LAP_CAPTURE_EN
                lap_q       <= '0;
                lap_valid_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_STOPPED: begin
                        // a tick alongside start is not counted
                        if (start_i) state_q <= S_RUNNING;
                    end
                    S_RUNNING: begin
                        if (stop_i) begin
                            state_q <= S_STOPPED;
                        end else if (tick_i) begin
                            if (end_hit_d && STOP_AT_END) begin
                                carry_q <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                count_q <= count_d;
                                carry_q <= end_hit_d;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_DONE;
                    end
                    default: state_q <= S_STOPPED;
                endcase
            end
        end
    end

    assign count_o   = count_q;
    assign carry_o   = carry_q;
    assign running_o = (state_q == S_RUNNING);
    assign done_o    = (state_q == S_DONE);

`ifdef LIM_COUNTER_LAP_CAPTURE_EN
    assign lap_count_o = lap_q;
    assign lap_valid_o = lap_valid_q;
`else
    assign lap_count_o = '0;
    assign lap_valid_o = 1'b0;
`endif

endmodule

// File: doc/lim_counter_chain.md
Name: lim_counter_chain

Overview:
- Parametrised mixed-radix counter chain: NUM_DIGITS cascaded digits, each counting modulo its own limit L_i.
- Each digit has saturating-input semantics: a digit value at or above L_i is treated as overflow.
- Adds registered state, run/stop control, up/down direction, synchronous load and end-of-range stop mode.
- Sits between the tick prescaler and the 7-segment display driver in the stopwatch datapath.

Parameters:
- NUM_DIGITS, 4, number of cascaded digits; digit 0 is least significant.
- DIGIT_W, 4, bits per digit; requires 2 <= L_i <= 2^DIGIT_W.
- LIMITS, 32'h060A060A, packed 8-bit limit per digit; byte i = L_i; default is mm:ss.
- STOP_AT_END, 0, 0 = wrap at range end; 1 = halt in DONE at range end.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- tick  in  1  single-cycle count-enable strobe from the prescaler.
- start  in  1  pulse; STOPPED -> RUNNING.
- stop  in  1  pulse; RUNNING -> STOPPED.
- clear  in  1  pulse; zero all digits, go to STOPPED.
- dir  in  1  0 = count up, 1 = count down; sampled with each tick.
- load  in  1  pulse; load load_val into the digits.
- load_val  in  NUM_DIGITS*DIGIT_W  packed digit values for load.
- count  out  NUM_DIGITS*DIGIT_W  registered packed digit values.
- carry_out  out  1  one-cycle pulse on full-chain wrap or borrow.
- running  out  1  high in RUNNING.
- done  out  1  high in DONE.
- lap_count  out  NUM_DIGITS*DIGIT_W  lap snapshot (optional feature).
- lap_valid  out  1  lap snapshot valid (optional feature).

Behaviour:
- Reset values: count=0, carry_out=0, running=0, done=0, lap_count=0, lap_valid=0, state=STOPPED.
- FSM states: STOPPED, RUNNING, DONE.
  - STOPPED -> RUNNING on start.
  - RUNNING -> STOPPED on stop.
  - RUNNING -> DONE on end-of-range, only when STOP_AT_END=1.
  - DONE -> STOPPED on clear or load only; start and stop are ignored in DONE.
- Same-cycle priority: reset > clear > load > stop > start > tick.
  - clear and load suppress tick in that cycle.
  - A start arriving with a tick in the same cycle does not count that tick; counting begins on the next tick.
- Counting:
  - Occurs only in RUNNING with tick=1.
  - count, carry_out and state update on the clock edge that samples tick (1-cycle latency).
- Up count:
  - Digit 0 gets +1. Digit i gets +1 iff all lower digits were at L_j-1.
  - A digit at L_i-1, or holding a value >= L_i, becomes 0 and carries.
- Down count:
  - Digit 0 gets -1. Digit i gets -1 iff all lower digits were 0.
  - A digit at 0 becomes L_i-1 and borrows. A digit holding a value >= L_i decrements to L_i-1 with no borrow.
- End of range:
  - Up: all digits at L_i-1 when the tick arrives.
  - Down: all digits 0 when the tick arrives.
  - STOP_AT_END=0: count wraps to all-0 (up) or all-max (down); carry_out=1 for exactly one cycle.
  - STOP_AT_END=1: count holds, carry_out=1 for one cycle, state -> DONE, further ticks ignored.
- Load:
  - Each field is saturated: a value >= L_i is stored as L_i-1.
  - State -> STOPPED. carry_out=0.
- dir may change between ticks. Reversing direction causes no glitch and no spurious carry_out.
- reset or clear mid-count: next cycle count=0, any pending carry_out is dropped, state=STOPPED.
- carry_out is never asserted in a cycle without a counted tick.

Optional Feature:
- Macro: LIM_COUNTER_LAP_CAPTURE_EN.
- Defined: adds input port lap (1 bit).
  - lap=1 in RUNNING or DONE: lap_count <= current count (pre-update value in a tick cycle); lap_valid <= 1.
  - clear, load and reset zero lap_count and lap_valid.
  - lap in STOPPED is ignored.
- Undefined: no lap port; lap_count and lap_valid are tied to 0.

Test Plan:
- Reset then start, 10 ticks, dir=0, defaults -> count=16'h0010, carry_out never 1, running=1.
- load 16'h5959, start, 1 tick -> count=16'h0000, carry_out high exactly one cycle.
- STOP_AT_END=1, load 16'h5958, start, 3 ticks -> count 16'h5959, done=1, carry_out pulses once, third tick ignored.
- dir=1, load 16'h0100, start, 1 tick -> count=16'h0059. Then load 16'h0000, start, 1 tick -> count=16'h5959, carry_out=1.
- load 16'hFFFF -> count=16'h5959. Same cycle clear+load+tick -> count=16'h0000, state STOPPED.
- LIM_COUNTER_LAP_CAPTURE_EN: running at 16'h0012, lap with tick -> lap_count=16'h0012, count=16'h0013, lap_valid=1. Then clear -> both lap outputs 0.
